// File: rtl/rob_multiport.sv
// In-order reorder buffer with multi-port dispatch, CDB writeback, bypassed operand reads
// and a ready/valid commit group that stops after an excepting entry.
`timescale 1ns/1ps
module rob_multiport #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned DISP_W = 2,
  parameter int unsigned CDB_W  = 2,
  parameter int unsigned CMT_W  = 2,
  parameter int unsigned RD_W   = 4,
  parameter int unsigned INFO_W = 64,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned ID_W  = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic [DISP_W-1:0]          disp_valid_i,
  input  logic [DISP_W*INFO_W-1:0]   disp_info_i,
  output logic                       disp_ready_o,
  output logic [DISP_W*ID_W-1:0]     disp_id_o,
  input  logic [CDB_W-1:0]           wb_valid_i,
  input  logic [CDB_W*ID_W-1:0]      wb_id_i,
  input  logic [CDB_W*DATA_W-1:0]    wb_data_i,
  input  logic [CDB_W-1:0]           wb_exc_i,
  input  logic [RD_W*ID_W-1:0]       rd_id_i,
  output logic [RD_W*DATA_W-1:0]     rd_data_o,
  output logic [RD_W-1:0]            rd_complete_o,
  output logic [CMT_W-1:0]           cmt_valid_o,
  input  logic [CMT_W-1:0]           cmt_ready_i,
  output logic [CMT_W*ID_W-1:0]      cmt_id_o,
  output logic [CMT_W*INFO_W-1:0]    cmt_info_o,
  output logic [CMT_W*DATA_W-1:0]    cmt_data_o,
  output logic [CMT_W-1:0]           cmt_exc_o,
  output logic [ID_W:0]              count_o,
  output logic                       empty_o
);

  localparam int unsigned CNT_W = ID_W + 1;

  logic [ID_W-1:0]   head_q, tail_q;
  logic [CNT_W-1:0]  count_q;
  logic [DEPTH-1:0]  valid_q, complete_q, exc_q;
  logic [INFO_W-1:0] info_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [ID_W-1:0]   disp_idx [DISP_W];
  logic [ID_W-1:0]   cmt_idx  [CMT_W];
  logic [ID_W-1:0]   wb_idx   [CDB_W];
  logic [ID_W-1:0]   rd_idx   [RD_W];
  logic [CNT_W-1:0]  n_disp, n_cmt;
  logic              cmt_run, cmt_take;

  // Backpressure uses registered occupancy only; a same-cycle commit frees nothing yet.
  assign disp_ready_o = (CNT_W'(DEPTH) - count_q) >= CNT_W'(DISP_W);
  assign count_o      = count_q;
  assign empty_o      = (count_q == '0);

  for (genvar k = 0; k < DISP_W; k++) begin : g_disp
    assign disp_idx[k]                   = tail_q + ID_W'(k);
    assign disp_id_o[k*ID_W +: ID_W]     = disp_idx[k];
  end

  for (genvar k = 0; k < CMT_W; k++) begin : g_cmt
    assign cmt_idx[k]                    = head_q + ID_W'(k);
    assign cmt_id_o[k*ID_W +: ID_W]      = cmt_idx[k];
    assign cmt_info_o[k*INFO_W +: INFO_W] = info_q[cmt_idx[k]];
    assign cmt_data_o[k*DATA_W +: DATA_W] = data_q[cmt_idx[k]];
    assign cmt_exc_o[k]                  = exc_q[cmt_idx[k]];
  end

  for (genvar j = 0; j < CDB_W; j++) begin : g_wb
    assign wb_idx[j] = wb_id_i[j*ID_W +: ID_W];
  end

  for (genvar r = 0; r < RD_W; r++) begin : g_rd
    assign rd_idx[r] = rd_id_i[r*ID_W +: ID_W];
  end

  // Dispatch count: the request is a prefix, so popcount equals the accepted slot count.
  always_comb begin
    n_disp = '0;
    for (int k = 0; k < DISP_W; k++) begin
      if (disp_valid_i[k]) n_disp = n_disp + CNT_W'(1);
    end
    if (!disp_ready_o) n_disp = '0;
  end

  // Commit group: contiguous completed entries from head, closed after the first exception.
  always_comb begin
    cmt_valid_o = '0;
    n_cmt       = '0;
    cmt_run     = 1'b1;
    cmt_take    = 1'b1;
    for (int k = 0; k < CMT_W; k++) begin
      cmt_valid_o[k] = cmt_run && (CNT_W'(k) < count_q) && complete_q[cmt_idx[k]];
      cmt_run        = cmt_valid_o[k] && !exc_q[cmt_idx[k]];
      cmt_take       = cmt_take && cmt_valid_o[k] && cmt_ready_i[k];
      if (cmt_take) n_cmt = n_cmt + CNT_W'(1);
    end
  end

  // Operand reads with writeback bypass; the highest matching CDB port wins.
  always_comb begin
    rd_data_o     = '0;
    rd_complete_o = '0;
    for (int r = 0; r < RD_W; r++) begin
      rd_data_o[r*DATA_W +: DATA_W] = data_q[rd_idx[r]];
      rd_complete_o[r]              = valid_q[rd_idx[r]] && complete_q[rd_idx[r]];
      for (int j = 0; j < CDB_W; j++) begin
        if (wb_valid_i[j] && (wb_idx[j] == rd_idx[r]) && valid_q[rd_idx[r]]) begin
          rd_data_o[r*DATA_W +: DATA_W] = wb_data_i[j*DATA_W +: DATA_W];
          rd_complete_o[r]              = 1'b1;
        end
      end
    end
  end

  // Control state: pointers, occupancy and per-entry flags.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      complete_q <= '0;
      exc_q      <= '0;
    end else begin
      for (int j = 0; j < CDB_W; j++) begin
        if (wb_valid_i[j] && valid_q[wb_idx[j]]) begin
          complete_q[wb_idx[j]] <= 1'b1;
          exc_q[wb_idx[j]]      <= wb_exc_i[j];
        end
      end
      for (int k = 0; k < CMT_W; k++) begin
        if (CNT_W'(k) < n_cmt) begin
          valid_q[cmt_idx[k]]    <= 1'b0;
          complete_q[cmt_idx[k]] <= 1'b0;
          exc_q[cmt_idx[k]]      <= 1'b0;
        end
      end
      for (int k = 0; k < DISP_W; k++) begin
        if (CNT_W'(k) < n_disp) begin
          valid_q[disp_idx[k]]    <= 1'b1;
          complete_q[disp_idx[k]] <= 1'b0;
          exc_q[disp_idx[k]]      <= 1'b0;
        end
      end
      head_q  <= head_q + ID_W'(n_cmt);
      tail_q  <= tail_q + ID_W'(n_disp);
      count_q <= count_q + n_disp - n_cmt;
    end
  end

  // Payload arrays carry no reset; their contents are qualified by the valid/complete flags.
  always_ff @(posedge clk) begin
    if (rst_n && !flush_i) begin
      for (int j = 0; j < CDB_W; j++) begin
        if (wb_valid_i[j] && valid_q[wb_idx[j]]) begin
          data_q[wb_idx[j]] <= wb_data_i[j*DATA_W +: DATA_W];
        end
      end
      for (int k = 0; k < DISP_W; k++) begin
        if (CNT_W'(k) < n_disp) begin
          info_q[disp_idx[k]] <= disp_info_i[k*INFO_W +: INFO_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_multiport.sv
// Randomized scoreboard bench for rob_multiport against an age-ordered queue model.
`timescale 1ns/1ps
module tb_rob_multiport;
  localparam int unsigned DEPTH = 64, DISP_W = 2, CDB_W = 2, CMT_W = 2, RD_W = 4;
  localparam int unsigned INFO_W = 64, DATA_W = 32, ID_W = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst_n = 1'b0, flush_i = 1'b0;
  logic [DISP_W-1:0]        disp_valid_i = '0;
  logic [DISP_W*INFO_W-1:0] disp_info_i = '0;
  logic                     disp_ready_o;
  logic [DISP_W*ID_W-1:0]   disp_id_o;
  logic [CDB_W-1:0]         wb_valid_i = '0, wb_exc_i = '0;
  logic [CDB_W*ID_W-1:0]    wb_id_i = '0;
  logic [CDB_W*DATA_W-1:0]  wb_data_i = '0;
  logic [RD_W*ID_W-1:0]     rd_id_i = '0;
  logic [RD_W*DATA_W-1:0]   rd_data_o;
  logic [RD_W-1:0]          rd_complete_o;
  logic [CMT_W-1:0]         cmt_valid_o, cmt_exc_o;
  logic [CMT_W-1:0]         cmt_ready_i = '0;
  logic [CMT_W*ID_W-1:0]    cmt_id_o;
  logic [CMT_W*INFO_W-1:0]  cmt_info_o;
  logic [CMT_W*DATA_W-1:0]  cmt_data_o;
  logic [ID_W:0]            count_o;
  logic                     empty_o;

  rob_multiport #(.DEPTH(DEPTH), .DISP_W(DISP_W), .CDB_W(CDB_W), .CMT_W(CMT_W),
                  .RD_W(RD_W), .INFO_W(INFO_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .disp_valid_i(disp_valid_i), .disp_info_i(disp_info_i),
    .disp_ready_o(disp_ready_o), .disp_id_o(disp_id_o),
    .wb_valid_i(wb_valid_i), .wb_id_i(wb_id_i), .wb_data_i(wb_data_i), .wb_exc_i(wb_exc_i),
    .rd_id_i(rd_id_i), .rd_data_o(rd_data_o), .rd_complete_o(rd_complete_o),
    .cmt_valid_o(cmt_valid_o), .cmt_ready_i(cmt_ready_i), .cmt_id_o(cmt_id_o),
    .cmt_info_o(cmt_info_o), .cmt_data_o(cmt_data_o), .cmt_exc_o(cmt_exc_o),
    .count_o(count_o), .empty_o(empty_o)
  );

  typedef struct {
    int                id;
    logic [INFO_W-1:0] info;
    logic [DATA_W-1:0] data;
    bit                complete;
    bit                exc;
  } ent_t;

  ent_t rob[$];   // in-flight entries, oldest first
  ent_t sb[$];    // expected retirements in order
  int   next_id = 0;
  int   n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic int find(input int id);
    for (int i = 0; i < rob.size(); i++) if (rob[i].id == id) return i;
    return -1;
  endfunction

  // One cycle: check outputs against the model, advance the model, cross the clock edge.
  task automatic step(input bit chk);
    bit ready_e, run, go;
    logic [CMT_W-1:0] ev;
    int idx, id, m;
    bit ec;
    logic [DATA_W-1:0] ed;
    ent_t e;
    #2;
    ready_e = (DEPTH - rob.size()) >= DISP_W;
    ev = '0; run = 1'b1;
    for (int k = 0; k < CMT_W; k++) begin
      if (run && k < rob.size() && rob[k].complete) ev[k] = 1'b1;
      run = ev[k] ? !rob[k].exc : 1'b0;
    end
    if (chk) begin
      check("disp_ready", 64'(disp_ready_o), 64'(ready_e));
      for (int k = 0; k < DISP_W; k++)
        check("disp_id", 64'(disp_id_o[k*ID_W +: ID_W]), 64'((next_id + k) % DEPTH));
      check("count", 64'(count_o), 64'(rob.size()));
      check("empty", 64'(empty_o), 64'(rob.size() == 0));
      check("cmt_valid", 64'(cmt_valid_o), 64'(ev));
      for (int r = 0; r < RD_W; r++) begin
        id = int'(rd_id_i[r*ID_W +: ID_W]);
        idx = find(id);
        ec = 1'b0; ed = '0;
        if (idx >= 0) begin
          ec = rob[idx].complete; ed = rob[idx].data;
          for (int j = 0; j < CDB_W; j++)
            if (wb_valid_i[j] && int'(wb_id_i[j*ID_W +: ID_W]) == id) begin
              ec = 1'b1; ed = wb_data_i[j*DATA_W +: DATA_W];
            end
        end
        check("rd_complete", 64'(rd_complete_o[r]), 64'(ec));
        if (ec) check("rd_data", 64'(rd_data_o[r*DATA_W +: DATA_W]), 64'(ed));
      end
    end
    if (!rst_n || flush_i) begin
      rob.delete();
      next_id = 0;
    end else begin
      go = 1'b1; m = 0;
      for (int k = 0; k < CMT_W; k++) begin
        go = go && ev[k] && cmt_ready_i[k];
        if (go) m++;
      end
      repeat (m) sb.push_back(rob.pop_front());
      for (int j = 0; j < CDB_W; j++)
        if (wb_valid_i[j]) begin
          idx = find(int'(wb_id_i[j*ID_W +: ID_W]));
          if (idx >= 0) begin
            rob[idx].complete = 1'b1;
            rob[idx].data = wb_data_i[j*DATA_W +: DATA_W];
            rob[idx].exc = wb_exc_i[j];
          end
        end
      if (ready_e)
        for (int k = 0; k < DISP_W; k++)
          if (disp_valid_i[k]) begin
            e.id = next_id; e.info = disp_info_i[k*INFO_W +: INFO_W];
            e.data = '0; e.complete = 1'b0; e.exc = 1'b0;
            rob.push_back(e);
            next_id = (next_id + 1) % DEPTH;
          end
    end
    @(posedge clk); #1;
  endtask

  // Commit monitor: every accepted commit slot must match the next expected retirement.
  always @(negedge clk) begin : mon
    ent_t e;
    bit go;
    if (rst_n === 1'b1 && flush_i === 1'b0) begin
      go = 1'b1;
      for (int k = 0; k < CMT_W; k++) begin
        go = go && (cmt_valid_o[k] === 1'b1) && cmt_ready_i[k];
        if (go) begin
          if (sb.size() == 0) begin
            check("cmt_unexpected", 64'(cmt_id_o[k*ID_W +: ID_W]), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = sb.pop_front();
            check("cmt_id", 64'(cmt_id_o[k*ID_W +: ID_W]), 64'(e.id));
            check("cmt_info", cmt_info_o[k*INFO_W +: INFO_W], e.info);
            check("cmt_data", 64'(cmt_data_o[k*DATA_W +: DATA_W]), 64'(e.data));
            check("cmt_exc", 64'(cmt_exc_o[k]), 64'(e.exc));
          end
        end
      end
    end
  end

  task automatic idle();
    rst_n = 1'b1; flush_i = 1'b0; disp_valid_i = '0; disp_info_i = '0;
    wb_valid_i = '0; wb_exc_i = '0; wb_id_i = '0; wb_data_i = '0;
    rd_id_i = '0; cmt_ready_i = '0;
  endtask

  task automatic set_wb(input int j, input int id, input logic [DATA_W-1:0] d, input bit x);
    wb_valid_i[j] = 1'b1;
    wb_id_i[j*ID_W +: ID_W] = ID_W'(id);
    wb_data_i[j*DATA_W +: DATA_W] = d;
    wb_exc_i[j] = x;
  endtask

  task automatic rand_info();
    disp_info_i = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic rand_inputs();
    int pick;
    idle();
    flush_i = ($urandom_range(0, 63) == 0);
    case ($urandom_range(0, 3))
      0: disp_valid_i = 2'b00;
      1: disp_valid_i = 2'b01;
      default: disp_valid_i = 2'b11;
    endcase
    rand_info();
    for (int j = 0; j < CDB_W; j++)
      if (rob.size() > 0 && $urandom_range(0, 2) != 0) begin
        pick = $urandom_range(0, rob.size() - 1);
        if (j == 0 || !wb_valid_i[0] || int'(wb_id_i[ID_W-1:0]) != rob[pick].id)
          set_wb(j, rob[pick].id, $urandom, $urandom_range(0, 7) == 0);
      end
    cmt_ready_i = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
    for (int r = 0; r < RD_W; r++)
      rd_id_i[r*ID_W +: ID_W] = (r < CDB_W && wb_valid_i[r]) ? wb_id_i[r*ID_W +: ID_W]
                                                            : ID_W'($urandom);
  endtask

  initial begin
    idle(); rst_n = 1'b0;
    @(posedge clk); #1;
    step(1'b0);
    step(1'b1);                             // reset values
    idle();
    // fill to full with two per cycle, then a rejected dispatch
    for (int i = 0; i < 33; i++) begin
      disp_valid_i = 2'b11; rand_info();
      rd_id_i = {ID_W'(i), ID_W'(i + 1), ID_W'(63), ID_W'(0)};
      step(1'b1);
    end
    idle();
    set_wb(0, 1, 32'h1111, 1'b0); step(1'b1);
    idle(); step(1'b1);
    set_wb(1, 0, 32'h0000_0AAA, 1'b0); step(1'b1);
    idle(); cmt_ready_i = 2'b11; step(1'b1);
    // exception stops the group after itself
    idle(); set_wb(0, 2, 32'hE0E0, 1'b1); set_wb(1, 3, 32'h3333, 1'b0); step(1'b1);
    idle(); cmt_ready_i = 2'b11; step(1'b1);
    idle(); cmt_ready_i = 2'b11; step(1'b1);
    // same-cycle bypass on a read port
    idle(); set_wb(1, 7, 32'hDEAD, 1'b0); rd_id_i = {ID_W'(9), ID_W'(8), ID_W'(7), ID_W'(7)};
    step(1'b1);
    idle(); rd_id_i = {ID_W'(9), ID_W'(8), ID_W'(7), ID_W'(7)}; step(1'b1);
    // flush concurrent with dispatch, writeback and commit
    idle(); set_wb(0, 4, 32'h4444, 1'b0); step(1'b1);
    idle(); flush_i = 1'b1; disp_valid_i = 2'b11; rand_info(); cmt_ready_i = 2'b11;
    set_wb(0, 5, 32'h5555, 1'b0); step(1'b1);
    idle(); step(1'b1);
    // march head/tail to 62, then dispatch across the wrap
    for (int i = 0; i < 32; i++) begin
      idle(); cmt_ready_i = 2'b11;
      if (i < 31) begin disp_valid_i = 2'b11; rand_info(); end
      if (i > 0) begin set_wb(0, 2*i - 2, $urandom, 1'b0); set_wb(1, 2*i - 1, $urandom, 1'b0); end
      step(1'b1);
    end
    repeat (3) begin idle(); cmt_ready_i = 2'b11; step(1'b1); end
    idle(); disp_valid_i = 2'b11; rand_info(); step(1'b1);
    idle(); disp_valid_i = 2'b11; rand_info(); set_wb(0, 62, 32'h62, 1'b0); set_wb(1, 63, 32'h63, 1'b0);
    step(1'b1);
    idle(); set_wb(0, 0, 32'h100, 1'b0); set_wb(1, 1, 32'h101, 1'b0); cmt_ready_i = 2'b11; step(1'b1);
    repeat (3) begin idle(); cmt_ready_i = 2'b11; step(1'b1); end
    // reset in the middle of traffic
    for (int i = 0; i < 10; i++) begin rand_inputs(); step(1'b1); end
    idle(); rst_n = 1'b0; disp_valid_i = 2'b11; cmt_ready_i = 2'b11; step(1'b1);
    idle(); step(1'b1);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin rand_inputs(); step(1'b1); end
    idle(); rst_n = 1'b0; step(1'b1);
    idle(); step(1'b1);
    @(negedge clk); #1;
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
